// File: rtl/sine_lut_scheduler_pkg.sv
// Shared constants and FSM encoding for the two-channel quarter-wave sine scheduler.
package sine_lut_scheduler_pkg;

  localparam int unsigned WS_PHASE_W = 32;
  localparam int unsigned WS_LUT_AW  = 10;
  localparam int unsigned WS_DATA_W  = 12;

  localparam logic                 RST_ACT     = 1'b1;
  localparam logic [WS_DATA_W-1:0] WS_MIDSCALE = 12'd2048;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRead = 2'd1,
    StCapt = 2'd2
  } ws_state_e;

endpackage

// File: rtl/sine_lut_scheduler_ws_edge_sync.sv
// Two-flop synchronizer for an asynchronous waveform clock, followed by a registered
// one-cycle pulse on each synchronized rising edge.
module ws_edge_sync
  import sine_lut_scheduler_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic pulse_o
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic hist_q, hist_d;
  logic pulse_q, pulse_d;

  always_comb begin
    sync1_d = d_i;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
    pulse_d = sync2_q & ~hist_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i == RST_ACT) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/sine_lut_scheduler.sv
// Two phase accumulators sharing one quarter-wave sine ROM port; a round-robin FSM
// schedules reads and rebuilds full-wave offset-binary samples from quadrant symmetry.
module sine_lut_scheduler
  import sine_lut_scheduler_pkg::*;
#(
  parameter int unsigned PHASE_W = WS_PHASE_W,
  parameter int unsigned LUT_AW  = WS_LUT_AW,
  parameter int unsigned DATA_W  = WS_DATA_W
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_i,
  input  logic              ws_en_i,
  input  logic              ws_clk_1_i,
  input  logic              ws_clk_2_i,
  input  logic [PHASE_W-1:0] ws_inc_1_i,
  input  logic [PHASE_W-1:0] ws_inc_2_i,
  output logic              ws_rom_rd_o,
  output logic [LUT_AW-1:0] ws_rom_addr_o,
  input  logic [DATA_W-1:0] ws_rom_data_i,
  output logic [DATA_W-1:0] ws_sine_1_o,
  output logic [DATA_W-1:0] ws_sine_2_o,
  output logic              ws_valid_1_o,
  output logic              ws_valid_2_o,
  output logic [1:0]        ws_overrun_o
);

  localparam int unsigned        PhW = LUT_AW + 2;
  localparam logic [DATA_W-1:0] Mid = {1'b1, {(DATA_W - 1){1'b0}}};

  logic [1:0]              ws_edge;
  logic [1:0][PHASE_W-1:0] inc;

  ws_state_e               state_q, state_d;
  logic [1:0][PHASE_W-1:0] acc_q, acc_d;
  logic [1:0]              pend_q, pend_d;
  logic [1:0]              ovr_q, ovr_d;
  logic                    rr_q, rr_d;      // 0 selects ch1 on a tie
  logic                    gnt_ch_q, gnt_ch_d;
  logic                    sign_q, sign_d;
  logic                    rd_q, rd_d;
  logic [LUT_AW-1:0]       addr_q, addr_d;
  logic [1:0][DATA_W-1:0]  sine_q, sine_d;
  logic [1:0]              valid_q, valid_d;

  logic [1:0]              gnt;
  logic                    gnt_ch;
  logic [PhW-1:0]          phase;
  logic [DATA_W-2:0]       mag;
  logic [DATA_W-1:0]       sample;
  logic                    unused_rom_msb;

  ws_edge_sync u_edge_1 (
    .clk_i   (sys_clk_i),
    .rst_i   (sys_rst_i),
    .d_i     (ws_clk_1_i),
    .pulse_o (ws_edge[0])
  );

  ws_edge_sync u_edge_2 (
    .clk_i   (sys_clk_i),
    .rst_i   (sys_rst_i),
    .d_i     (ws_clk_2_i),
    .pulse_o (ws_edge[1])
  );

  assign inc = {ws_inc_2_i, ws_inc_1_i};

  // The ROM holds magnitude only; the sign comes from the latched quadrant.
  assign mag            = ws_rom_data_i[DATA_W-2:0];
  assign unused_rom_msb = ws_rom_data_i[DATA_W-1];
  assign sample         = sign_q ? (Mid - {1'b0, mag}) : (Mid + {1'b0, mag});

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    pend_d   = pend_q;
    ovr_d    = ovr_q;
    rr_d     = rr_q;
    gnt_ch_d = gnt_ch_q;
    sign_d   = sign_q;
    addr_d   = addr_q;
    sine_d   = sine_q;
    rd_d     = 1'b0;
    valid_d  = '0;
    gnt      = '0;
    gnt_ch   = 1'b0;
    phase    = '0;

    if (!ws_en_i) begin
      state_d = StIdle;
      acc_d   = '0;
      pend_d  = '0;
      ovr_d   = '0;
      sine_d  = {Mid, Mid};
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|pend_q) begin
            gnt_ch      = (&pend_q) ? rr_q : ~pend_q[0];
            gnt[gnt_ch] = 1'b1;
            phase       = acc_q[gnt_ch][PHASE_W-1 -: PhW];
            gnt_ch_d    = gnt_ch;
            sign_d      = phase[PhW-1];
            // Odd quadrants walk the quarter table backwards.
            addr_d      = phase[PhW-2] ? ~phase[LUT_AW-1:0] : phase[LUT_AW-1:0];
            rd_d        = 1'b1;
            state_d     = StRead;
          end
        end
        StRead: state_d = StCapt;
        StCapt: begin
          sine_d[gnt_ch_q]  = sample;
          valid_d[gnt_ch_q] = 1'b1;
          rr_d              = ~gnt_ch_q;
          state_d           = StIdle;
        end
        default: state_d = StIdle;
      endcase

      // A new edge wins over the grant's clear, so a same-cycle edge stays pending.
      for (int c = 0; c < 2; c++) begin
        if (gnt[c]) begin
          pend_d[c] = 1'b0;
        end
        if (ws_edge[c]) begin
          acc_d[c] = acc_q[c] + inc[c];
          if (pend_q[c] && !gnt[c]) begin
            ovr_d[c] = 1'b1;
          end
          pend_d[c] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i == RST_ACT) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      pend_q   <= '0;
      ovr_q    <= '0;
      rr_q     <= 1'b0;
      gnt_ch_q <= 1'b0;
      sign_q   <= 1'b0;
      rd_q     <= 1'b0;
      addr_q   <= '0;
      sine_q   <= {Mid, Mid};
      valid_q  <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
      rr_q     <= rr_d;
      gnt_ch_q <= gnt_ch_d;
      sign_q   <= sign_d;
      rd_q     <= rd_d;
      addr_q   <= addr_d;
      sine_q   <= sine_d;
      valid_q  <= valid_d;
    end
  end

  assign ws_rom_rd_o   = rd_q;
  assign ws_rom_addr_o = addr_q;
  assign ws_sine_1_o   = sine_q[0];
  assign ws_sine_2_o   = sine_q[1];
  assign ws_valid_1_o  = valid_q[0];
  assign ws_valid_2_o  = valid_q[1];
  assign ws_overrun_o  = ovr_q;

endmodule
